// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared definitions for the elevator scheduler: FSM state codes, car
// direction command codes, the default number of floors and the width of
// the floor number reported by the car.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 8;
  localparam int FLOOR_W        = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_DOOR  = 3'd3,
    S_CLOSE = 3'd4,
    S_FAULT = 3'd5
  } sched_state_t;

  typedef enum logic [1:0] {
    UD_STOP = 2'b00,
    UD_UP   = 2'b01,
    UD_DOWN = 2'b10
  } updown_t;

endpackage

// File: rtl/elevator_call_logic.sv
// elevator_call_logic
// Purely combinational summary of the outstanding-call vector relative to
// the car's current floor.
// Ports:
//   pending    in  outstanding calls, one bit per floor
//   floor      in  current car floor
//   call_here  out a call is outstanding at the current floor
//   call_above out a call is outstanding at some floor above the car
//   call_below out a call is outstanding at some floor below the car
module elevator_call_logic import elevator_pkg::*; #(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  call_here,
  output logic                  call_above,
  output logic                  call_below
);

  logic [31:0] floor_ext;

  assign floor_ext = 32'(floor);

  // An out-of-range floor simply matches no bit; the scheduler faults on it.
  always_comb begin
    call_here  = 1'b0;
    call_above = 1'b0;
    call_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (32'(i) == floor_ext) call_here  = 1'b1;
        if (32'(i) >  floor_ext) call_above = 1'b1;
        if (32'(i) <  floor_ext) call_below = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
// SCAN-style single-car scheduler: latches floor calls, drives the car
// up/down, runs the door dwell timer and a move watchdog, and latches a
// sticky fault on watchdog expiry or inconsistent car feedback.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   call_req     level call buttons, one per floor
//   hold_req     door-hold button
//   floor        current floor reported by the car
//   door         car door feedback, 1 = open
//   updown       registered car command (00 stop, 01 up, 10 down)
//   door_open    registered door-open command
//   pending      registered outstanding-call vector
//   sched_state  current FSM state code
//   fault        registered sticky fault flag
//
// state   | meaning
// IDLE    | stopped, door closed, choosing the next direction
// UP      | travelling up, stops at the first floor with a call
// DOWN    | travelling down, stops at the first floor with a call
// DOOR    | door held open for the dwell time
// CLOSE   | door commanded shut, waiting for door feedback
// FAULT   | sticky halt, left only through reset
module elevator_scheduler import elevator_pkg::*; #(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int DOOR_CYCLES  = 10,
  parameter int MOVE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  hold_req,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  door,
  output logic [1:0]            updown,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [2:0]            sched_state,
  output logic                  fault
);

  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
  localparam int MOVE_W = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [MOVE_W-1:0] MOVE_LOAD = MOVE_W'(MOVE_TIMEOUT - 1);
  localparam logic [31:0]       TOP_FLOOR = 32'(NUM_FLOORS - 1);

  sched_state_t state, next_state;

  logic                  run_en;
  logic [FLOOR_W-1:0]    floor_q;
  logic                  dir_up;
  logic [DOOR_W-1:0]     door_cnt;
  logic [MOVE_W-1:0]     move_tmr;

  logic [31:0]           floor_ext;
  logic                  floor_valid;
  logic                  floor_chg;
  logic                  moving;
  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic                  call_req_here;
  logic                  door_reload;
  logic                  call_here, call_above, call_below;

  elevator_call_logic #(.NUM_FLOORS(NUM_FLOORS)) u_call_logic (
    .pending    (pending),
    .floor      (floor),
    .call_here  (call_here),
    .call_above (call_above),
    .call_below (call_below)
  );

  assign floor_ext   = 32'(floor);
  assign floor_valid = (floor_ext < 32'(NUM_FLOORS));
  assign floor_chg   = (floor != floor_q);
  assign moving      = (state == S_UP) || (state == S_DOWN);
  assign sched_state = state;

  always_comb begin
    here_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) here_mask[i] = (32'(i) == floor_ext);
  end

  assign call_req_here = |(call_req & here_mask);
  assign door_reload   = hold_req | call_req_here;

  // Deassertion is retimed through one flop so the first state update lands
  // on the second rising edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= S_IDLE;
    else if (run_en) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (call_here)                 next_state = S_DOOR;
        else if (dir_up && call_above) next_state = S_UP;
        else if (call_below)           next_state = S_DOWN;
        else if (call_above)           next_state = S_UP;
      end
      S_UP: begin
        if (floor_chg && call_here)                  next_state = S_DOOR;
        else if (floor_ext == TOP_FLOOR && !call_here) next_state = S_IDLE;
        else if (!floor_chg && move_tmr == '0)       next_state = S_FAULT;
      end
      S_DOWN: begin
        if (floor_chg && call_here)                  next_state = S_DOOR;
        else if (floor_ext == 32'd0 && !call_here)   next_state = S_IDLE;
        else if (!floor_chg && move_tmr == '0)       next_state = S_FAULT;
      end
      S_DOOR: begin
        if (!door_reload && door_cnt == '0) next_state = S_CLOSE;
      end
      S_CLOSE: begin
        if (door && call_req_here) next_state = S_DOOR;
        else if (!door)            next_state = S_IDLE;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FAULT;
    endcase
    if (!floor_valid || (door && moving)) next_state = S_FAULT;
  end

  // A call at the floor being entered as DOOR is already served, so the
  // clear wins; while the door is open at a floor its button only extends
  // the dwell and must not leave a stale call behind.
  assign clear_mask = (next_state == S_DOOR && state != S_DOOR) ? here_mask : '0;
  assign set_mask   = call_req & ~((state == S_DOOR) ? here_mask : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      floor_q   <= '0;
      dir_up    <= 1'b1;
      door_cnt  <= '0;
      move_tmr  <= '0;
      updown    <= UD_STOP;
      door_open <= 1'b0;
      fault     <= 1'b0;
    end else if (run_en) begin
      floor_q <= floor;

      if (state != S_FAULT) pending <= (pending | set_mask) & ~clear_mask;

      if (next_state == S_UP)        dir_up <= 1'b1;
      else if (next_state == S_DOWN) dir_up <= 1'b0;

      if (next_state == S_DOOR && (state != S_DOOR || door_reload))
        door_cnt <= DOOR_LOAD;
      else if (state == S_DOOR && door_cnt != '0)
        door_cnt <= door_cnt - DOOR_W'(1);

      // Watchdog rests at its load value outside the move states so the
      // first move cycle already counts.
      if (moving) begin
        if (floor_chg)             move_tmr <= MOVE_LOAD;
        else if (move_tmr != '0)   move_tmr <= move_tmr - MOVE_W'(1);
      end else begin
        move_tmr <= MOVE_LOAD;
      end

      case (next_state)
        S_UP:    updown <= UD_UP;
        S_DOWN:  updown <= UD_DOWN;
        default: updown <= UD_STOP;
      endcase
      door_open <= (next_state == S_DOOR);
      fault     <= fault | (next_state == S_FAULT);
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] call_req = '0;
  logic       hold_req = 1'b0;
  logic [2:0] floor = '0;
  logic       door = 1'b0;
  logic [1:0] updown;
  logic       door_open;
  logic [7:0] pending;
  logic [2:0] sched_state;
  logic       fault;

  logic [5:0] call6 = '0;
  logic       hold6 = 1'b0;
  logic [2:0] floor6 = '0;
  logic       door6 = 1'b0;
  logic [1:0] updown6;
  logic       door_open6;
  logic [5:0] pending6;
  logic [2:0] state6;
  logic       fault6;

  int checks = 0;
  int errors = 0;

  elevator_scheduler dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .hold_req(hold_req),
    .floor(floor), .door(door), .updown(updown), .door_open(door_open),
    .pending(pending), .sched_state(sched_state), .fault(fault)
  );

  elevator_scheduler #(.NUM_FLOORS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .call_req(call6), .hold_req(hold6),
    .floor(floor6), .door(door6), .updown(updown6), .door_open(door_open6),
    .pending(pending6), .sched_state(state6), .fault(fault6)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just past the first edge after release; the next edge
  // is the first one on which the scheduler updates.
  task automatic do_reset();
    rst_n = 1'b0;
    call_req = '0; hold_req = 1'b0; floor = '0; door = 1'b0;
    call6 = '0; hold6 = 1'b0; floor6 = '0; door6 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (updown !== 2'b00) begin errors++; $display("FAIL reset_updown got %0b exp 00", updown); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door_open got %0b exp 0", door_open); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %0h exp 00", pending); end
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", sched_state); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fault); end
    call_req = 8'h04;
    rst_n = 1'b1;
    tick();
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_sync_edge1 pending got %0h exp 00", pending); end
    tick();
    checks++; if (pending !== 8'h04) begin errors++; $display("FAIL reset_sync_edge2 pending got %0h exp 04", pending); end
    call_req = '0;
  endtask

  task automatic test_door_here();
    int hi;
    do_reset();
    call_req = 8'h01;
    tick();
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL here_pending_set got %0h exp 01", pending); end
    call_req = 8'h00;
    tick();
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL here_latency door_open got %0b exp 1", door_open); end
    checks++; if (sched_state !== 3'd3) begin errors++; $display("FAIL here_state got %0d exp 3", sched_state); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL here_pending_clr got %0h exp 00", pending); end
    checks++; if (updown !== 2'b00) begin errors++; $display("FAIL here_updown got %0b exp 00", updown); end
    hi = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (door_open === 1'b1) hi++;
    end
    checks++; if (hi !== 10) begin errors++; $display("FAIL here_open_cycles got %0d exp 10", hi); end
    door = 1'b1;
    tick();
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL here_close_door_open got %0b exp 0", door_open); end
    checks++; if (sched_state !== 3'd4) begin errors++; $display("FAIL here_close_state got %0d exp 4", sched_state); end
    tick();
    checks++; if (sched_state !== 3'd4) begin errors++; $display("FAIL here_close_wait got %0d exp 4", sched_state); end
    door = 1'b0;
    tick();
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL here_idle got %0d exp 0", sched_state); end
  endtask

  task automatic test_hold();
    int hi;
    do_reset();
    call_req = 8'h01;
    tick();
    call_req = 8'h00;
    tick();
    repeat (7) tick();
    hold_req = 1'b1;
    tick();
    hold_req = 1'b0;
    hi = (door_open === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (door_open === 1'b1) hi++;
    end
    checks++; if (hi !== 10) begin errors++; $display("FAIL hold_open_cycles got %0d exp 10", hi); end
    tick();
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL hold_closes got %0b exp 0", door_open); end
  endtask

  task automatic test_move_up();
    int up_ok;
    do_reset();
    call_req = 8'h20;
    tick();
    call_req = 8'h00;
    tick();
    checks++; if (updown !== 2'b01) begin errors++; $display("FAIL up_start updown got %0b exp 01", updown); end
    checks++; if (sched_state !== 3'd1) begin errors++; $display("FAIL up_start state got %0d exp 1", sched_state); end
    up_ok = 0;
    for (int f = 1; f <= 4; f++) begin
      floor = 3'(f);
      tick();
      if (updown === 2'b01) up_ok++;
    end
    checks++; if (up_ok !== 4) begin errors++; $display("FAIL up_passing cycles got %0d exp 4", up_ok); end
    floor = 3'd5;
    tick();
    checks++; if (updown !== 2'b00) begin errors++; $display("FAIL up_arrive updown got %0b exp 00", updown); end
    checks++; if (sched_state !== 3'd3) begin errors++; $display("FAIL up_arrive state got %0d exp 3", sched_state); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL up_arrive pending got %0h exp 00", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL async_rst_door got %0b exp 0", door_open); end
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL async_rst_state got %0d exp 0", sched_state); end
  endtask

  task automatic test_scan();
    int ok;
    do_reset();
    floor = 3'd3;
    call_req = 8'h81;
    tick();
    call_req = 8'h00;
    tick();
    checks++; if (updown !== 2'b01) begin errors++; $display("FAIL scan_first_up got %0b exp 01", updown); end
    ok = 0;
    for (int f = 4; f <= 6; f++) begin
      floor = 3'(f);
      tick();
      if (sched_state === 3'd1) ok++;
    end
    checks++; if (ok !== 3) begin errors++; $display("FAIL scan_pass_up got %0d exp 3", ok); end
    floor = 3'd7;
    tick();
    checks++; if (sched_state !== 3'd3) begin errors++; $display("FAIL scan_door7 got %0d exp 3", sched_state); end
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL scan_pend7 got %0h exp 01", pending); end
    repeat (10) tick();
    checks++; if (sched_state !== 3'd4) begin errors++; $display("FAIL scan_close7 got %0d exp 4", sched_state); end
    tick();
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL scan_idle7 got %0d exp 0", sched_state); end
    tick();
    checks++; if (updown !== 2'b10) begin errors++; $display("FAIL scan_down_start got %0b exp 10", updown); end
    floor = 3'd6;
    tick();
    checks++; if (updown !== 2'b10) begin errors++; $display("FAIL scan_down6 got %0b exp 10", updown); end
    call_req = 8'h20;
    tick();
    call_req = 8'h00;
    floor = 3'd5;
    tick();
    checks++; if (sched_state !== 3'd3) begin errors++; $display("FAIL scan_door5 got %0d exp 3", sched_state); end
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL scan_pend5 got %0h exp 01", pending); end
    repeat (10) tick();
    tick();
    tick();
    checks++; if (updown !== 2'b10) begin errors++; $display("FAIL scan_resume_down got %0b exp 10", updown); end
    for (int f = 4; f >= 1; f--) begin
      floor = 3'(f);
      tick();
    end
    floor = 3'd0;
    tick();
    checks++; if (sched_state !== 3'd3) begin errors++; $display("FAIL scan_door0 got %0d exp 3", sched_state); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL scan_pend0 got %0h exp 00", pending); end
  endtask

  task automatic test_watchdog();
    do_reset();
    call_req = 8'h80;
    tick();
    call_req = 8'h00;
    tick();
    repeat (63) tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wd_early fault got %0b exp 0", fault); end
    checks++; if (sched_state !== 3'd1) begin errors++; $display("FAIL wd_early state got %0d exp 1", sched_state); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wd_fault got %0b exp 1", fault); end
    checks++; if (updown !== 2'b00) begin errors++; $display("FAIL wd_updown got %0b exp 00", updown); end
    checks++; if (sched_state !== 3'd5) begin errors++; $display("FAIL wd_state got %0d exp 5", sched_state); end
    call_req = 8'h04;
    tick();
    call_req = 8'h00;
    checks++; if (pending !== 8'h80) begin errors++; $display("FAIL wd_frozen pending got %0h exp 80", pending); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wd_sticky got %0b exp 1", fault); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wd_rst_fault got %0b exp 0", fault); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL wd_rst_pending got %0h exp 00", pending); end
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL wd_rst_state got %0d exp 0", sched_state); end
  endtask

  task automatic test_bad_inputs();
    do_reset();
    call_req = 8'h10;
    tick();
    call_req = 8'h00;
    tick();
    door = 1'b1;
    tick();
    checks++; if (sched_state !== 3'd5) begin errors++; $display("FAIL door_in_move state got %0d exp 5", sched_state); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL door_in_move fault got %0b exp 1", fault); end
    floor6 = 3'd5;
    tick();
    checks++; if (fault6 !== 1'b0) begin errors++; $display("FAIL top_floor6 fault got %0b exp 0", fault6); end
    floor6 = 3'd6;
    tick();
    checks++; if (fault6 !== 1'b1) begin errors++; $display("FAIL floor6_range fault got %0b exp 1", fault6); end
    checks++; if (state6 !== 3'd5) begin errors++; $display("FAIL floor6_range state got %0d exp 5", state6); end
    do_reset();
    floor6 = 3'd7;
    tick();
    checks++; if (fault6 !== 1'b1) begin errors++; $display("FAIL floor7_range fault got %0b exp 1", fault6); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL floor7_other fault got %0b exp 0", fault); end
  endtask

  initial begin
    test_reset();
    test_door_here();
    test_hold();
    test_move_up();
    test_scan();
    test_watchdog();
    test_bad_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 NUM_FLOORS, 8, floors served, numbered 0..NUM_FLOORS-1.
REQ-002 DOOR_CYCLES, 10, clock cycles door_open is held high per stop.
REQ-003 MOVE_TIMEOUT, 64, max cycles in a move state without a floor change before fault.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 call_req  input  NUM_FLOORS  level call buttons; bit i high in a cycle registers a call for floor i.
REQ-007 hold_req  input  1  door-hold button; restarts door timer while in DOOR.
REQ-008 floor  input  3  current floor reported by the elevator car.
REQ-009 door  input  1  car door status feedback, 1 = open.
REQ-010 updown  output  2  registered car command: 00 stop, 01 up, 10 down, 11 never driven.
REQ-011 door_open  output  1  registered door-open command to the car.
REQ-012 pending  output  NUM_FLOORS  registered outstanding-call vector.
REQ-013 sched_state  output  3  current FSM state code.
REQ-014 fault  output  1  registered, sticky fault flag.

Function
REQ-015 FSM states/codes: IDLE=0, UP=1, DOWN=2, DOOR=3, CLOSE=4, FAULT=5; other codes unreachable, decode to FAULT.
REQ-016 pending[i] sets on the edge after call_req[i]=1; clears only on entry to DOOR at floor i; set-and-clear same cycle at same floor -> clear wins (car already there).
REQ-017 dir_up register (reset 1) records last travel direction.
REQ-018 IDLE: pending[floor] -> DOOR; else dir_up and any call above -> UP; else any call below -> DOWN; else any call above -> UP; else stay IDLE.
REQ-019 UP: updown=01, dir_up=1; on a cycle where floor differs from its previous registered value and pending[floor]=1 -> DOOR with updown=00 next edge.
REQ-020 DOWN: mirror of UP with updown=10, dir_up=0.
REQ-021 UP reaching floor NUM_FLOORS-1, or DOWN reaching 0, with no call there -> IDLE, updown=00.
REQ-022 DOOR: door_open=1, updown=00, door counter loads DOOR_CYCLES-1 on entry, decrements each cycle; hold_req=1 or call_req[floor]=1 reloads it; counter 0 -> CLOSE.
REQ-023 CLOSE: door_open=0; door=0 -> IDLE; call_req[floor]=1 while door=1 -> back to DOOR.
REQ-024 Move watchdog counts cycles in UP/DOWN since last floor change; reaching MOVE_TIMEOUT -> FAULT.
REQ-025 floor >= NUM_FLOORS in any state, or door=1 while in UP/DOWN -> FAULT on next edge.
REQ-026 FAULT: updown=00, door_open=0, fault=1, pending frozen; exit only via rst_n.
REQ-027 Latency: call at an idle car's current floor -> door_open=1 two edges after call_req asserts.
REQ-028 Simultaneous calls above and below from IDLE resolved by dir_up (SCAN); no call is skipped while passing its floor in the current direction.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, updown=00, door_open=0, pending=0, fault=0, dir_up=1, counters 0.
REQ-030 Reset mid-move or mid-door takes effect immediately; outputs return to reset values without waiting for a clock edge.
REQ-031 Deassertion is synchronous to clk; first state update on second rising edge after rst_n rises.

Structure
REQ-032 Package elevator_pkg holds: state codes, updown codes (STOP/UP/DOWN), NUM_FLOORS default, floor width.
REQ-033 One sub-module elevator_call_logic: combinational, from pending and floor produces call_here, call_above, call_below.
REQ-034 Timers and FSM remain in elevator_scheduler; no other sub-modules.

Verification
REQ-035 Reset, floor=0, call_req=8'h01 one cycle -> door_open=1 after 2 edges, high 10 cycles, pending=0, then CLOSE -> IDLE when door=0.
REQ-036 Idle at 0, call_req=8'h20 -> updown=01; model steps floor 1..5 -> updown=00, DOOR at floor 5, pending[5]=0.
REQ-037 Car at 3, dir_up=1, calls 8'h81 together -> serves 7 first, then 0; floor 5 call injected while descending past it is served.
REQ-038 In DOOR, hold_req pulsed at counter=2 -> door_open stays high 10 more cycles.
REQ-039 In UP, floor frozen 64 cycles -> fault=1, updown=00; call_req ignored; rst_n low -> all outputs 0 immediately.
REQ-040 floor=3'd7 with NUM_FLOORS=6, or door=1 during UP -> FAULT next edge.
